// File: rtl/cop0_ctrl.sv
// -----------------------------------------------------------------------------
// cop0_ctrl
//   System control coprocessor (CP0) for the single-cycle MIPS core.
//   Owns Status, Cause, EPC, Count, Compare and TrapCode. It serves mfc0/mtc0,
//   handles syscall/break/eret and hardware interrupts, and tells the PC unit
//   when and where to redirect.
//
//   Optional feature macro: COP0_TIMER_EN
//     defined   -> Count/Compare timer, prescaler and Cause.TI are built.
//     undefined -> Count/Compare read 0, ignore writes, TI is constant 0.
//
// Parameters
//   NUM_HW_INT : external interrupt lines (1..6) -> Cause.IP[2..NUM_HW_INT+1]
//   EXC_VECTOR : exception / interrupt entry address
//   COUNT_DIV  : clock cycles per Count increment (>= 1)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   reg_num, reg_sel    : CP0 register address (num, sel)
//   in_data, reg_wr     : mtc0 data and strobe
//   reg_rd, out_data    : mfc0 strobe and combinational read data (0 if idle)
//   cop_op, code        : 001 syscall, 010 break, 011 eret; trap code field
//   next_pc             : address of the next sequential instruction
//   hw_int              : level-sensitive interrupt requests
//   exc_taken           : combinational PC redirect request
//   exc_target          : combinational redirect address
//   status_exl          : Status.EXL
//
// No handshakes: every strobe is a single-cycle qualifier, sampled at the
// rising edge; there is no back-pressure.
// -----------------------------------------------------------------------------
module cop0_ctrl #(
   parameter int          NUM_HW_INT = 6,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            reg_num,
   input  logic [2:0]            reg_sel,
   input  logic [31:0]           in_data,
   input  logic                  reg_wr,
   input  logic                  reg_rd,
   output logic [31:0]           out_data,
   input  logic [2:0]            cop_op,
   input  logic [19:0]           code,
   input  logic [31:0]           next_pc,
   input  logic [NUM_HW_INT-1:0] hw_int,
   output logic                  exc_taken,
   output logic [31:0]           exc_target,
   output logic                  status_exl
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_TRAP    = 5'd22;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BRK  = 5'd9;

   // Architectural state
   logic [7:0]            im_q,   im_d;
   logic                  exl_q,  exl_d;
   logic                  ie_q,   ie_d;
   logic [NUM_HW_INT-1:0] hw_q,   hw_d;
   logic [4:0]            exc_code_q, exc_code_d;
   logic [31:0]           epc_q,  epc_d;
   logic [19:0]           trap_q, trap_d;
   logic                  ti;

`ifdef COP0_TIMER_EN
   logic [31:0]           count_q,   count_d;
   logic [31:0]           compare_q, compare_d;
   logic [31:0]           presc_q,   presc_d;
   logic                  ti_q,      ti_d;
   logic                  cnt_inc;
   logic [31:0]           count_inc_val;
`endif

   // Decode
   logic       sel0;
   logic       wr_status, wr_epc;
   logic       is_sys, is_brk, is_eret;
   logic [7:0] ip;
   logic       int_req;
   logic       entry;

   assign sel0      = (reg_sel == 3'd0);
   assign wr_status = reg_wr && sel0 && (reg_num == REG_STATUS);
   assign wr_epc    = reg_wr && sel0 && (reg_num == REG_EPC);

   assign is_sys  = (cop_op == 3'b001);
   assign is_brk  = (cop_op == 3'b010);
   assign is_eret = (cop_op == 3'b011);

`ifdef COP0_TIMER_EN
   assign ti = ti_q;
`else
   assign ti = 1'b0;
`endif

   // IP[7] carries both hw_int[5] (when present) and the timer flag.
   always_comb begin
      ip = 8'h00;
      for (int k = 0; k < NUM_HW_INT; k++) begin
         ip[k+2] = hw_q[k];
      end
      ip[7] = ip[7] | ti;
   end

   assign int_req = ie_q & ~exl_q & (|(ip & im_q));

   // Syscall/break outrank the interrupt; a pending interrupt outranks eret,
   // so an eret in that cycle becomes an interrupt entry instead.
   assign entry = is_sys | is_brk | int_req;

   assign exc_taken  = entry | is_eret;
   assign exc_target = entry ? EXC_VECTOR : epc_q;
   assign status_exl = exl_q;

   // Next-state for the exception-side registers
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      hw_d       = hw_int;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      trap_d     = trap_q;

      if (wr_status) begin
         im_d  = in_data[15:8];
         exl_d = in_data[1];
         ie_d  = in_data[0];
      end
      if (wr_epc) begin
         epc_d = in_data;
      end

      // Event updates to EXL/EPC are applied after mtc0 so they override it.
      if (entry) begin
         exl_d = 1'b1;
         if (!exl_q) begin
            epc_d = next_pc;
         end
         if (is_sys) begin
            exc_code_d = EXC_SYS;
            trap_d     = code;
         end else if (is_brk) begin
            exc_code_d = EXC_BRK;
            trap_d     = code;
         end else begin
            exc_code_d = EXC_INT;
         end
      end else if (is_eret) begin
         exl_d = 1'b0;
      end
   end

`ifdef COP0_TIMER_EN
   // Timer next-state
   always_comb begin
      presc_d       = presc_q;
      count_d       = count_q;
      compare_d     = compare_q;
      ti_d          = ti_q;
      cnt_inc       = 1'b0;
      count_inc_val = count_q + 32'd1;

      if (presc_q >= 32'(COUNT_DIV - 1)) begin
         presc_d = 32'd0;
         cnt_inc = 1'b1;
      end else begin
         presc_d = presc_q + 32'd1;
      end

      if (reg_wr && sel0 && (reg_num == REG_COUNT)) begin
         // A software write replaces the increment and never raises TI.
         count_d = in_data;
      end else if (cnt_inc) begin
         count_d = count_inc_val;
         if (count_inc_val == compare_q) begin
            ti_d = 1'b1;
         end
      end

      // Compare write clears TI and wins over a same-cycle set.
      if (reg_wr && sel0 && (reg_num == REG_COMPARE)) begin
         compare_d = in_data;
         ti_d      = 1'b0;
      end
   end
`endif

   // Read mux
   always_comb begin
      out_data = 32'h0;
      if (reg_rd && sel0) begin
         case (reg_num)
`ifdef COP0_TIMER_EN
            REG_COUNT:   out_data = count_q;
            REG_COMPARE: out_data = compare_q;
`endif
            REG_STATUS:  out_data = {16'h0, im_q, 6'h0, exl_q, ie_q};
            REG_CAUSE:   out_data = {1'b0, ti, 14'h0, ip, 1'b0, exc_code_q, 2'b00};
            REG_EPC:     out_data = epc_q;
            REG_TRAP:    out_data = {12'h0, trap_q};
            default:     out_data = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         im_q       <= 8'h0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         hw_q       <= '0;
         exc_code_q <= 5'd0;
         epc_q      <= 32'h0;
         trap_q     <= 20'h0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         hw_q       <= hw_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         trap_q     <= trap_d;
      end
   end

`ifdef COP0_TIMER_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'hFFFF_FFFF;
         presc_q   <= 32'h0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         presc_q   <= presc_d;
         ti_q      <= ti_d;
      end
   end
`endif

endmodule

// File: tb/tb_cop0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cop0_ctrl
//   Directed bench for cop0_ctrl (NUM_HW_INT=6, EXC_VECTOR=0x180,
//   COUNT_DIV=2). Inputs change 1 time unit after the rising edge and
//   outputs are sampled 1 unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_cop0_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  reg_num;
   logic [2:0]  reg_sel;
   logic [31:0] in_data;
   logic        reg_wr;
   logic        reg_rd;
   logic [31:0] out_data;
   logic [2:0]  cop_op;
   logic [19:0] code;
   logic [31:0] next_pc;
   logic [5:0]  hw_int;
   logic        exc_taken;
   logic [31:0] exc_target;
   logic        status_exl;

   int n_checks = 0;
   int n_errors = 0;

   cop0_ctrl #(
      .NUM_HW_INT (6),
      .EXC_VECTOR (32'h0000_0180),
      .COUNT_DIV  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_num    (reg_num),
      .reg_sel    (reg_sel),
      .in_data    (in_data),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .out_data   (out_data),
      .cop_op     (cop_op),
      .code       (code),
      .next_pc    (next_pc),
      .hw_int     (hw_int),
      .exc_taken  (exc_taken),
      .exc_target (exc_target),
      .status_exl (status_exl)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] num, input logic [2:0] sel,
                         input logic [31:0] exp);
      reg_num = num;
      reg_sel = sel;
      reg_rd  = 1'b1;
      #1;
      chk(tag, out_data, exp);
      reg_rd  = 1'b0;
      reg_sel = 3'd0;
   endtask

   task automatic peek(input logic [4:0] num, output logic [31:0] v);
      reg_num = num;
      reg_sel = 3'd0;
      reg_rd  = 1'b1;
      #1;
      v = out_data;
      reg_rd  = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] num, input logic [31:0] d);
      reg_num = num;
      reg_sel = 3'd0;
      in_data = d;
      reg_wr  = 1'b1;
   endtask

   task automatic idle();
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      cop_op = 3'b000;
   endtask

   initial begin
      logic [31:0] v;
      logic        seen;

      rst = 1'b1; reg_num = 5'd0; reg_sel = 3'd0; in_data = 32'h0;
      reg_wr = 1'b0; reg_rd = 1'b0; cop_op = 3'b000; code = 20'h0;
      next_pc = 32'h0; hw_int = 6'h0;
      tick(); tick(); tick();

      // Reset state
      #1;
      chk("rst_out_idle", out_data, 32'h0);
      chk("rst_taken", {31'h0, exc_taken}, 32'h0);
      chk("rst_exl", {31'h0, status_exl}, 32'h0);
      rst = 1'b0;
      tick();
      rd_chk("rst_status", 5'd12, 3'd0, 32'h0);
      rd_chk("rst_cause",  5'd13, 3'd0, 32'h0);
      rd_chk("rst_epc",    5'd14, 3'd0, 32'h0);
`ifdef COP0_TIMER_EN
      rd_chk("rst_compare", 5'd11, 3'd0, 32'hFFFF_FFFF);
`else
      rd_chk("rst_compare", 5'd11, 3'd0, 32'h0);
`endif

      // Syscall entry
      tick();
      cop_op = 3'b001; code = 20'hABCDE; next_pc = 32'h0000_3004;
      #1;
      chk("sys_taken", {31'h0, exc_taken}, 32'h1);
      chk("sys_target", exc_target, 32'h180);
      tick(); idle();
      rd_chk("sys_epc",   5'd14, 3'd0, 32'h3004);
      rd_chk("sys_cause", 5'd13, 3'd0, 32'h20);
      rd_chk("sys_status", 5'd12, 3'd0, 32'h2);
      rd_chk("sys_trap",  5'd22, 3'd0, 32'h000A_BCDE);
      chk("sys_exl", {31'h0, status_exl}, 32'h1);

      // eret back
      cop_op = 3'b011;
      #1;
      chk("eret_taken", {31'h0, exc_taken}, 32'h1);
      chk("eret_target", exc_target, 32'h3004);
      tick(); idle();
      chk("eret_exl", {31'h0, status_exl}, 32'h0);

      // Interrupt: IM[2]=1, IE=1
      mtc0(5'd12, 32'h0000_0401);
      tick(); idle();
      hw_int = 6'h01; next_pc = 32'h0000_5000;
      #1;
      chk("int_latency0", {31'h0, exc_taken}, 32'h0);
      tick();
      chk("int_taken", {31'h0, exc_taken}, 32'h1);
      chk("int_target", exc_target, 32'h180);
      tick();
      rd_chk("int_epc",   5'd14, 3'd0, 32'h5000);
      rd_chk("int_cause", 5'd13, 3'd0, 32'h400);
      rd_chk("int_status", 5'd12, 3'd0, 32'h403);
      chk("int_exl_block", {31'h0, exc_taken}, 32'h0);

      // Mask with IM[2]=0 while clearing EXL
      mtc0(5'd12, 32'h0000_0001);
      tick(); idle();
      chk("int_masked", {31'h0, exc_taken}, 32'h0);

      // Unmask, then eret in the same cycle as a pending interrupt
      mtc0(5'd12, 32'h0000_0401);
      tick(); idle();
      cop_op = 3'b011; next_pc = 32'h0000_6000;
      #1;
      chk("eret_int_target", exc_target, 32'h180);
      tick(); idle();
      rd_chk("eret_int_epc", 5'd14, 3'd0, 32'h6000);
      chk("eret_int_exl", {31'h0, status_exl}, 32'h1);

      // Break with pending interrupt
      mtc0(5'd12, 32'h0000_0401);
      tick(); idle();
      cop_op = 3'b010; code = 20'h12345; next_pc = 32'h0000_7000;
      #1;
      chk("brk_target", exc_target, 32'h180);
      tick(); idle();
      rd_chk("brk_cause", 5'd13, 3'd0, 32'h424);
      rd_chk("brk_epc",   5'd14, 3'd0, 32'h7000);
      rd_chk("brk_trap",  5'd22, 3'd0, 32'h0001_2345);

      // mtc0 Status=0 together with syscall while EXL=1
      hw_int = 6'h00;
      mtc0(5'd12, 32'h0);
      cop_op = 3'b001; code = 20'h00001; next_pc = 32'h0000_8000;
      tick(); idle();
      rd_chk("sim_status", 5'd12, 3'd0, 32'h2);
      rd_chk("sim_epc",    5'd14, 3'd0, 32'h7000);
      rd_chk("sim_cause",  5'd13, 3'd0, 32'h20);

      // eret then mtc0 EPC
      cop_op = 3'b011;
      #1;
      chk("eret2_target", exc_target, 32'h7000);
      tick(); idle();
      mtc0(5'd14, 32'h0000_1234);
      tick(); idle();
      rd_chk("epc_wr", 5'd14, 3'd0, 32'h1234);
      rd_chk("unmapped_sel", 5'd12, 3'd1, 32'h0);
      rd_chk("unmapped_num", 5'd3,  3'd0, 32'h0);

      // hw_int[5] alone drives IP[7]
      hw_int = 6'h20;
      tick();
      rd_chk("ip7_hw5", 5'd13, 3'd0, 32'h8020);
      hw_int = 6'h00;
      tick();

`ifdef COP0_TIMER_EN
      // Timer: Compare=5, Count=0 -> TI after about 10 cycles
      mtc0(5'd11, 32'd5);
      tick();
      mtc0(5'd9, 32'd0);
      tick(); idle();
      seen = 1'b0;
      for (int i = 0; i < 14 && !seen; i++) begin
         peek(5'd13, v);
         if (v[30]) seen = 1'b1;
         else tick();
      end
      chk("ti_set", {31'h0, seen}, 32'h1);
      rd_chk("ti_count", 5'd9, 3'd0, 32'd5);
      tick(); tick(); tick();
      rd_chk("ti_sticky", 5'd13, 3'd0, 32'h4000_8020);
      mtc0(5'd11, 32'h0000_FFFF);
      tick(); idle();
      rd_chk("ti_clear", 5'd13, 3'd0, 32'h20);
      mtc0(5'd9, 32'hFFFF_FFFF);
      tick(); idle();
      v = 32'hFFFF_FFFF;
      for (int i = 0; i < 4 && v == 32'hFFFF_FFFF; i++) begin
         tick();
         peek(5'd9, v);
      end
      chk("count_wrap", v, 32'h0);
`else
      // Timer compiled out
      mtc0(5'd9, 32'h1234_5678);
      tick();
      mtc0(5'd11, 32'h0000_0003);
      tick(); idle();
      tick(); tick(); tick(); tick();
      rd_chk("no_timer_count",   5'd9,  3'd0, 32'h0);
      rd_chk("no_timer_compare", 5'd11, 3'd0, 32'h0);
      rd_chk("no_timer_ti",      5'd13, 3'd0, 32'h20);
`endif

      // Reset mid-operation beats mtc0 and syscall
      mtc0(5'd12, 32'h0000_FF03);
      cop_op = 3'b001; next_pc = 32'h0000_9000;
      rst = 1'b1;
      tick(); idle();
      rst = 1'b0;
      rd_chk("rst_mid_status", 5'd12, 3'd0, 32'h0);
      rd_chk("rst_mid_epc",    5'd14, 3'd0, 32'h0);
      rd_chk("rst_mid_trap",   5'd22, 3'd0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
